cobra_param_core: RTL and testbench

- Parametrised successor to the fixed single-cycle CYBERcobra lab processor.
- Same instruction format, generalised in data width, switch width and program depth.
- New over the fixed core: writable program memory, an explicit IDLE/RUN/HALT control FSM with a HALT instruction, and step/run execution gating.
- Sits at board top level between the switch/LED wrapper and a program loader (UART or bench).

---
 rtl/cobra_pkg.sv | 50 +++++
 rtl/cobra_alu.sv | 49 ++++
 rtl/cobra_param_core.sv | 142 ++++++++++++++
 tb/tb_cobra_param_core.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobra_pkg.sv
// Shared encodings for the parametrised CYBERcobra core: ALU opcodes,
// write-select values, control states and instruction field positions.
package cobra_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_GEU  = 5'b11111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;

  localparam logic [1:0] WS_CONST = 2'd0;
  localparam logic [1:0] WS_ALU   = 2'd1;
  localparam logic [1:0] WS_SW    = 2'd2;
  localparam logic [1:0] WS_ZERO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int F_J        = 31;
  localparam int F_B        = 30;
  localparam int F_WS_HI    = 29;
  localparam int F_WS_LO    = 28;
  localparam int F_OP_HI    = 27;
  localparam int F_OP_LO    = 23;
  localparam int F_RA1_HI   = 22;
  localparam int F_RA1_LO   = 18;
  localparam int F_RA2_HI   = 17;
  localparam int F_RA2_LO   = 13;
  localparam int F_OFFS_HI  = 12;
  localparam int F_OFFS_LO  = 5;
  localparam int F_WA_HI    = 4;
  localparam int F_WA_LO    = 0;
  localparam int F_CONST_HI = 27;
  localparam int F_CONST_LO = 5;

endpackage

// File: rtl/cobra_alu.sv
// Combinational ALU: result ops drive result_o, compare ops drive flag_o;
// the other output stays zero, and unknown opcodes give zero on both.
module cobra_alu
  import cobra_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            flag_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic            ltS;
  logic            ltU;

  assign shamt = b_i[SH_W-1:0];
  assign ltS   = $signed(a_i) < $signed(b_i);
  assign ltU   = a_i < b_i;

  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_SLTS: result_o = {{(XLEN-1){1'b0}}, ltS};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, ltU};
      ALU_LTS:  flag_o   = ltS;
      ALU_LTU:  flag_o   = ltU;
      ALU_GES:  flag_o   = !ltS;
      ALU_GEU:  flag_o   = !ltU;
      ALU_EQ:   flag_o   = a_i == b_i;
      ALU_NE:   flag_o   = a_i != b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/cobra_param_core.sv
// Single-cycle parametrised CYBERcobra core with writable program memory,
// IDLE/RUN/HALT control and run/step execution gating.
module cobra_param_core
  import cobra_pkg::*;
#(
  parameter int  XLEN       = 32,
  parameter int  SW_W       = 16,
  parameter int  NREG       = 32,
  parameter int  IMEM_DEPTH = 64,
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            run_i,
  input  logic            step_i,
  input  logic            start_i,
  input  logic            prog_we_i,
  input  logic [PC_W-1:0] prog_addr_i,
  input  logic [31:0]     prog_data_i,
  output logic [XLEN-1:0] out_o,
  output logic [PC_W-1:0] pc_o,
  output logic            halted_o,
  output logic            busy_o
);

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] regs_q [1:NREG-1];

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic [31:0]     instr;
  logic            isJ, isB;
  logic [1:0]      ws;
  logic [4:0]      aluOp, ra1, ra2, wa;
  logic [7:0]      offs;
  logic [PC_W-1:0] offsPc;
  logic [XLEN-1:0] constVal, swExt, rdA, rdB, aluResult, wdata;
  logic            aluFlag, exec, regWe;

  assign instr    = imem[pc_q];
  assign isJ      = instr[F_J];
  assign isB      = instr[F_B];
  assign ws       = instr[F_WS_HI:F_WS_LO];
  assign aluOp    = instr[F_OP_HI:F_OP_LO];
  assign ra1      = instr[F_RA1_HI:F_RA1_LO];
  assign ra2      = instr[F_RA2_HI:F_RA2_LO];
  assign offs     = instr[F_OFFS_HI:F_OFFS_LO];
  assign wa       = instr[F_WA_HI:F_WA_LO];
  // Widen first, then cut to the target width, so the same code serves every XLEN/PC_W.
  assign constVal = XLEN'({{41{instr[F_CONST_HI]}}, instr[F_CONST_HI:F_CONST_LO]});
  assign swExt    = XLEN'({{XLEN{1'b0}}, sw_i});
  assign offsPc   = PC_W'({{24{offs[7]}}, offs});
  assign exec     = (state_q == ST_RUN) && (run_i || step_i);

  // x0 and indices at or above NREG fall through to zero.
  always_comb begin
    rdA = '0;
    rdB = '0;
    for (int k = 1; k < NREG; k++) begin
      if (ra1 == 5'(k)) rdA = regs_q[k];
      if (ra2 == 5'(k)) rdB = regs_q[k];
    end
  end

  cobra_alu #(.XLEN(XLEN)) u_alu (
    .op_i     (aluOp),
    .a_i      (rdA),
    .b_i      (rdB),
    .result_o (aluResult),
    .flag_o   (aluFlag)
  );

  always_comb begin
    case (ws)
      WS_CONST: wdata = constVal;
      WS_ALU:   wdata = aluResult;
      WS_SW:    wdata = swExt;
      default:  wdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    regWe   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (exec) begin
          case ({isJ, isB})
            2'b11: state_d = ST_HALT;
            2'b00: begin
              regWe = 1'b1;
              pc_d  = pc_q + PC_W'(1);
            end
            2'b10:   pc_d = pc_q + offsPc;
            default: pc_d = aluFlag ? pc_q + offsPc : pc_q + PC_W'(1);
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 1; k < NREG; k++) regs_q[k] <= '0;
    end else if (regWe) begin
      for (int k = 1; k < NREG; k++) begin
        if (wa == 5'(k)) regs_q[k] <= wdata;
      end
    end
  end

  // Program memory survives reset so a loaded program can be restarted.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && (state_q != ST_RUN)) imem[prog_addr_i] <= prog_data_i;
  end

  assign out_o    = rdA;
  assign pc_o     = pc_q;
  assign halted_o = (state_q == ST_HALT);
  assign busy_o   = (state_q == ST_RUN);

endmodule

// File: tb/tb_cobra_param_core.sv
// Self-checking bench for cobra_param_core: directed programs plus a random
// phase, all compared against an instruction-level reference model.
module tb_cobra_param_core;

  localparam int XLEN  = 32;
  localparam int SW_W  = 16;
  localparam int NREG  = 32;
  localparam int DEPTH = 64;
  localparam int PC_W  = 6;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [SW_W-1:0] sw_i;
  logic            run_i, step_i, start_i, prog_we_i;
  logic [PC_W-1:0] prog_addr_i;
  logic [31:0]     prog_data_i;
  logic [XLEN-1:0] out_o;
  logic [PC_W-1:0] pc_o;
  logic            halted_o, busy_o;

  cobra_param_core #(
    .XLEN(XLEN), .SW_W(SW_W), .NREG(NREG), .IMEM_DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sw_i        (sw_i),
    .run_i       (run_i),
    .step_i      (step_i),
    .start_i     (start_i),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
    .out_o       (out_o),
    .pc_o        (pc_o),
    .halted_o    (halted_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: 0 = idle, 1 = running, 2 = halted.
  int          mState;
  int          mPc;
  logic [31:0] mRegs [NREG];
  logic [31:0] mMem  [DEPTH];
  logic [15:0] swVal;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkConst(input logic [4:0] wa, input logic [22:0] c);
    return {4'b0000, c, wa};
  endfunction
  function automatic logic [31:0] mkSw(input logic [4:0] wa);
    return {4'b0010, 23'd0, wa};
  endfunction
  function automatic logic [31:0] mkAlu(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] wa);
    return {4'b0001, op, a, b, 8'd0, wa};
  endfunction
  function automatic logic [31:0] mkJmp(input logic [7:0] offs);
    return {4'b1000, 15'd0, offs, 5'd0};
  endfunction
  function automatic logic [31:0] mkBr(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b, input logic [7:0] offs);
    return {4'b0100, op, a, b, offs, 5'd0};
  endfunction
  function automatic logic [31:0] mkHalt(input logic [4:0] a);
    return {4'b1100, 5'd0, a, 18'd0};
  endfunction

  function automatic logic [31:0] regRd(input logic [4:0] i);
    if (i == 0 || int'(i) >= NREG) return 32'd0;
    return mRegs[i];
  endfunction

  // ALU behaviour expressed through 64-bit integer arithmetic.
  task automatic aluRef(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output bit f);
    longint sa, sb, ua, ub, sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = longint'(b[4:0]);
    r = 32'd0;
    f = 1'b0;
    case (op)
      5'b00000: r = 32'(ua + ub);
      5'b01000: r = 32'(ua - ub);
      5'b00100: r = a ^ b;
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b00001: r = 32'(ua * (64'd1 << sh));
      5'b00101: r = 32'(ua / (64'd1 << sh));
      5'b01101: r = 32'(sa >>> sh);
      5'b00010: r = (sa < sb) ? 32'd1 : 32'd0;
      5'b00011: r = (ua < ub) ? 32'd1 : 32'd0;
      5'b11100: f = sa < sb;
      5'b11110: f = ua < ub;
      5'b11101: f = sa >= sb;
      5'b11111: f = ua >= ub;
      5'b11000: f = ua == ub;
      5'b11001: f = ua != ub;
      default: ;
    endcase
  endtask

  task automatic modelReset();
    mState = 0;
    mPc    = 0;
    for (int i = 0; i < NREG; i++) mRegs[i] = 32'd0;
  endtask

  task automatic modelStep(input logic [15:0] sw, input bit run, input bit step, input bit start,
                           input bit we, input logic [5:0] addr, input logic [31:0] data);
    logic [31:0] ins, r, v;
    logic [7:0]  offsB;
    longint      c;
    int          offs;
    bit          f;
    if (mState != 1) begin
      if (we) mMem[addr] = data;
      if (start) begin
        mState = 1;
        mPc    = 0;
      end
    end else if (run || step) begin
      ins   = mMem[mPc];
      offsB = ins[12:5];
      offs  = int'($signed(offsB));
      aluRef(ins[27:23], regRd(ins[22:18]), regRd(ins[17:13]), r, f);
      if (ins[31] && ins[30]) begin
        mState = 2;
      end else if (!ins[31] && !ins[30]) begin
        c = longint'(ins[27:5]);
        if (ins[27]) c = c - 64'h80_0000;
        case (ins[29:28])
          2'd0:    v = 32'(c);
          2'd1:    v = r;
          2'd2:    v = {16'd0, sw};
          default: v = 32'd0;
        endcase
        if (ins[4:0] != 0 && int'(ins[4:0]) < NREG) mRegs[ins[4:0]] = v;
        mPc = (mPc + 1) % DEPTH;
      end else if (ins[31] || f) begin
        mPc = (((mPc + offs) % DEPTH) + DEPTH) % DEPTH;
      end else begin
        mPc = (mPc + 1) % DEPTH;
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] sw, input bit run, input bit step, input bit start,
                               input bit we, input logic [5:0] addr, input logic [31:0] data);
    logic [31:0] w;
    sw_i        = sw;
    run_i       = run;
    step_i      = step;
    start_i     = start;
    prog_we_i   = we;
    prog_addr_i = addr;
    prog_data_i = data;
    @(posedge clk_i);
    modelStep(sw, run, step, start, we, addr, data);
    #1;
    w = mMem[mPc];
    checkOutput("pc", 64'(pc_o), 64'(mPc));
    checkOutput("busy", 64'(busy_o), 64'(mState == 1));
    checkOutput("halted", 64'(halted_o), 64'(mState == 2));
    checkOutput("out", 64'(out_o), 64'(regRd(w[22:18])));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(swVal, 0, 0, 0, 0, 6'd0, 32'd0);
  endtask
  task automatic writeWord(input logic [5:0] addr, input logic [31:0] data);
    applyStimulus(swVal, 0, 0, 0, 1, addr, data);
  endtask
  task automatic startPulse(input bit run);
    applyStimulus(swVal, run, 0, 1, 0, 6'd0, 32'd0);
  endtask
  task automatic runCycles(input int n);
    repeat (n) applyStimulus(swVal, 1, 0, 0, 0, 6'd0, 32'd0);
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    logic [4:0]  ops [16];
    int          cls;
    ops = '{5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111, 5'b00001, 5'b00101, 5'b01101,
            5'b00010, 5'b00011, 5'b11100, 5'b11110, 5'b11101, 5'b11111, 5'b11000, 5'b11001};
    w   = $urandom;
    cls = int'($urandom_range(0, 15));
    if ($urandom_range(0, 7) != 0) w[27:23] = ops[$urandom_range(0, 15)];
    if (cls == 0)      w[31:30] = 2'b11;
    else if (cls < 3)  w[31:30] = 2'b10;
    else if (cls < 6)  w[31:30] = 2'b01;
    else               w[31:30] = 2'b00;
    return w;
  endfunction

  initial begin
    swVal       = 16'h0108;
    sw_i        = swVal;
    run_i       = 0;
    step_i      = 0;
    start_i     = 0;
    prog_we_i   = 0;
    prog_addr_i = '0;
    prog_data_i = '0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = 32'd0;
    modelReset();

    rst_i = 0;
    #10;
    rst_i = 1;
    checkOutput("rst_pc", 64'(pc_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_halted", 64'(halted_o), 64'd0);
    checkOutput("rst_out", 64'(out_o), 64'd0);
    idleCycles(10);

    for (int i = 0; i < DEPTH; i++) writeWord(6'(i), mkHalt(5'd0));

    $display("[TB] constant/switch/ALU program");
    writeWord(6'd0, mkConst(5'd1, 23'd5));
    writeWord(6'd1, mkSw(5'd2));
    writeWord(6'd2, mkAlu(5'b00000, 5'd1, 5'd2, 5'd3));
    writeWord(6'd3, mkHalt(5'd3));
    startPulse(1);
    runCycles(4);
    checkOutput("prog1_halted", 64'(halted_o), 64'd1);
    checkOutput("prog1_pc", 64'(pc_o), 64'd3);
    checkOutput("prog1_r3", 64'(out_o), 64'h10D);

    $display("[TB] async reset mid-run");
    startPulse(1);
    runCycles(2);
    #3;
    rst_i = 0;
    #1;
    checkOutput("arst_pc", 64'(pc_o), 64'd0);
    checkOutput("arst_busy", 64'(busy_o), 64'd0);
    checkOutput("arst_out", 64'(out_o), 64'd0);
    modelReset();
    #2;
    rst_i = 1;
    startPulse(1);
    runCycles(4);
    checkOutput("arst_rerun_r3", 64'(out_o), 64'h10D);
    checkOutput("arst_rerun_halted", 64'(halted_o), 64'd1);

    $display("[TB] branch loop");
    writeWord(6'd0, mkConst(5'd1, 23'd3));
    writeWord(6'd1, mkConst(5'd2, 23'd1));
    writeWord(6'd2, mkAlu(5'b01000, 5'd1, 5'd2, 5'd1));
    writeWord(6'd3, mkBr(5'b11001, 5'd1, 5'd0, 8'hFF));
    writeWord(6'd4, mkHalt(5'd1));
    startPulse(1);
    runCycles(8);
    checkOutput("loop_not_yet_halted", 64'(halted_o), 64'd0);
    runCycles(1);
    checkOutput("loop_halted", 64'(halted_o), 64'd1);
    checkOutput("loop_pc", 64'(pc_o), 64'd4);
    checkOutput("loop_r1", 64'(out_o), 64'd0);

    $display("[TB] step mode");
    for (int i = 0; i < 6; i++) writeWord(6'(i), mkConst(5'd5, 23'(i + 1)));
    writeWord(6'd6, mkHalt(5'd5));
    startPulse(0);
    for (int p = 1; p <= 5; p++) begin
      applyStimulus(swVal, 0, 1, 0, 0, 6'd0, 32'd0);
      checkOutput("step_pc", 64'(pc_o), 64'(p));
      repeat (4) begin
        applyStimulus(swVal, 0, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("step_hold_pc", 64'(pc_o), 64'(p));
      end
    end
    runCycles(2);
    checkOutput("step_halted", 64'(halted_o), 64'd1);
    checkOutput("step_r5", 64'(out_o), 64'd6);

    $display("[TB] program write protection");
    writeWord(6'd0, mkConst(5'd4, 23'h11));
    writeWord(6'd1, mkHalt(5'd4));
    startPulse(0);
    applyStimulus(swVal, 0, 0, 0, 1, 6'd0, mkConst(5'd4, 23'h22));
    runCycles(2);
    checkOutput("wp_ignored_r4", 64'(out_o), 64'h11);
    applyStimulus(swVal, 0, 0, 1, 1, 6'd0, mkConst(5'd4, 23'h33));
    runCycles(2);
    checkOutput("wp_newword_r4", 64'(out_o), 64'h33);
    checkOutput("wp_halted", 64'(halted_o), 64'd1);

    $display("[TB] negative constant and backward wrap");
    writeWord(6'd0, mkConst(5'd1, 23'h7FFFFF));
    writeWord(6'd1, mkHalt(5'd1));
    startPulse(1);
    runCycles(2);
    checkOutput("negconst_r1", 64'(out_o), 64'hFFFF_FFFF);
    writeWord(6'd0, mkJmp(8'hFF));
    startPulse(0);
    applyStimulus(swVal, 0, 1, 0, 0, 6'd0, 32'd0);
    checkOutput("jmp_wrap_pc", 64'(pc_o), 64'(DEPTH - 1));
    runCycles(1);
    checkOutput("jmp_wrap_halted", 64'(halted_o), 64'd1);

    $display("[TB] random programs and controls");
    for (int i = 0; i < DEPTH; i++) writeWord(6'(i), randInstr());
    for (int n = 0; n < 600; n++) begin
      swVal = 16'($urandom);
      applyStimulus(swVal, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                    6'($urandom), randInstr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
